// File: rtl/dot11_tx_pkg.sv
// Shared definitions for the dot11_tx transmit path.
//   DOT11_AW   : BRAM address width used by dot11_tx and its scheduler
//   TO_CNT_W   : width of the scheduler's shared timeout/gap counter
//   tx_state_e : transmit scheduler FSM states
package dot11_tx_pkg;

    localparam int DOT11_AW = 10;
    localparam int TO_CNT_W = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_START,
        ST_WAIT_DONE,
        ST_ABORT,
        ST_GAP
    } tx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i   : request vector, one bit per queue
//   ptr_i   : highest-priority queue index this round
//   gnt_o   : first requesting index at or after ptr_i, wrapping
//   valid_o : at least one request present
module rr_arbiter #(
    parameter int NUM_Q = 4
) (
    input  logic [NUM_Q-1:0]         req_i,
    input  logic [$clog2(NUM_Q)-1:0] ptr_i,
    output logic [$clog2(NUM_Q)-1:0] gnt_o,
    output logic                     valid_o
);
    localparam int QW = $clog2(NUM_Q);

    logic [QW-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        // Scan from the farthest offset down so the nearest request
        // after the pointer is the last write and therefore wins.
        for (int i = NUM_Q - 1; i >= 0; i--) begin
            idx = QW'((int'(ptr_i) + i) % NUM_Q);
            if (req_i[idx]) begin
                gnt_o   = idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dot11_tx_sched.sv
// Transmit scheduler in front of dot11_tx.
//   clk, rstn          : clock and synchronous active-low reset
//   enable             : allow new grants (a running frame always completes)
//   ifs_cycles         : idle gap after each frame or abort
//   q_req / q_base     : per-queue request level and BRAM base address
//   q_done / q_err     : per-queue one-cycle completion / timeout pulses
//   busy, cur_q        : scheduler active and granted queue index
//   phy_tx_*           : start/started/done handshake and abort reset to core
//   core_bram_addr     : core address, rebased onto the granted queue's base
//   bram_addr          : combinational rebased address to the TX BRAM
module dot11_tx_sched
    import dot11_tx_pkg::*;
#(
    parameter int NUM_Q      = 4,
    parameter int AW         = DOT11_AW,
    parameter int START_TO   = 64,
    parameter int FRAME_TO   = 1000000,
    parameter int RST_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     enable,
    input  logic [15:0]              ifs_cycles,
    input  logic [NUM_Q-1:0]         q_req,
    input  logic [NUM_Q*AW-1:0]      q_base,
    output logic [NUM_Q-1:0]         q_done,
    output logic [NUM_Q-1:0]         q_err,
    output logic                     busy,
    output logic [$clog2(NUM_Q)-1:0] cur_q,
    output logic                     phy_tx_start,
    input  logic                     phy_tx_started,
    input  logic                     phy_tx_done,
    output logic                     phy_tx_arest,
    input  logic [AW-1:0]            core_bram_addr,
    output logic [AW-1:0]            bram_addr
);
    localparam int QW = $clog2(NUM_Q);
    localparam logic [TO_CNT_W-1:0] START_LAST = TO_CNT_W'(START_TO - 1);
    localparam logic [TO_CNT_W-1:0] FRAME_LAST = TO_CNT_W'(FRAME_TO - 1);
    localparam logic [TO_CNT_W-1:0] RST_LAST   = TO_CNT_W'(RST_CYCLES - 1);

    tx_state_e           state_q;
    logic [QW-1:0]       ptr_q;
    logic [QW-1:0]       cur_q_q;
    logic [TO_CNT_W-1:0] cnt_q;
    logic                start_q;
    logic                arest_q;
    logic                busy_q;
    logic [NUM_Q-1:0]    done_q;
    logic [NUM_Q-1:0]    err_q;

    logic [QW-1:0]       gnt_idx;
    logic                gnt_valid;
    logic [QW-1:0]       ptr_next;
    logic [NUM_Q-1:0]    cur_onehot;
    logic [16:0]         gap_next;
    logic                gap_end;

    rr_arbiter #(.NUM_Q(NUM_Q)) u_arb (
        .req_i   (q_req),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt_idx),
        .valid_o (gnt_valid)
    );

    assign ptr_next   = (gnt_idx == QW'(NUM_Q - 1)) ? '0 : gnt_idx + QW'(1);
    assign cur_onehot = {{(NUM_Q-1){1'b0}}, 1'b1} << cur_q_q;

    // The gap lasts max(ifs_cycles, 1) cycles: a zero gap still spends
    // one cycle in GAP before returning to IDLE.
    assign gap_next = {1'b0, cnt_q[15:0]} + 17'd1;
    assign gap_end  = gap_next >= {1'b0, ifs_cycles};

    // Base is selected by the registered grant so the core sees its BRAM
    // data one cycle after presenting an address; wraps modulo 2^AW.
    assign bram_addr = q_base[int'(cur_q_q) * AW +: AW] + core_bram_addr;

    assign q_done       = done_q;
    assign q_err        = err_q;
    assign busy         = busy_q;
    assign cur_q        = cur_q_q;
    assign phy_tx_start = start_q;
    assign phy_tx_arest = arest_q;

    // NOTE: all state updates use non-blocking assignments; the pulse
    // defaults at the top are simply overridden by later assignments.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cur_q_q <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            arest_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (enable && |q_req) begin
                        state_q <= ST_ARB;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ARB: begin
                    if (gnt_valid) begin
                        cur_q_q <= gnt_idx;
                        ptr_q   <= ptr_next;
                        start_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_START;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (phy_tx_started) begin
                        start_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_DONE;
                    end else if (cnt_q == START_LAST) begin
                        start_q <= 1'b0;
                        arest_q <= 1'b1;
                        err_q   <= cur_onehot;
                        cnt_q   <= '0;
                        state_q <= ST_ABORT;
                    end else begin
                        cnt_q <= cnt_q + TO_CNT_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    // A late or repeated started pulse is ignored here,
                    // so done always wins when both arrive together.
                    if (phy_tx_done) begin
                        done_q  <= cur_onehot;
                        cnt_q   <= '0;
                        state_q <= ST_GAP;
                    end else if (cnt_q == FRAME_LAST) begin
                        arest_q <= 1'b1;
                        err_q   <= cur_onehot;
                        cnt_q   <= '0;
                        state_q <= ST_ABORT;
                    end else begin
                        cnt_q <= cnt_q + TO_CNT_W'(1);
                    end
                end
                ST_ABORT: begin
                    if (cnt_q == RST_LAST) begin
                        arest_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + TO_CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_end) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + TO_CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dot11_tx_sched.md
# dot11_tx_sched

Transmit scheduler in front of `dot11_tx`. It arbitrates round-robin among `NUM_Q` frame queues whose frames are pre-staged in the shared TX BRAM. For the granted queue it rebases the core's BRAM address, sequences `phy_tx_start` → `phy_tx_started` → `phy_tx_done`, and enforces an inter-frame gap. Start or frame timeouts abort the core via its reset and report an error per queue.

## Interface
Parameters:
- `NUM_Q`, 4: number of requesting queues (2..8)
- `AW`, 10: BRAM address width, matches `dot11_tx` `bram_addr`
- `START_TO`, 64: cycles allowed from start assertion to `phy_tx_started`
- `FRAME_TO`, 1000000: cycles allowed from `phy_tx_started` to `phy_tx_done`; counter is 20 bits
- `RST_CYCLES`, 4: length of the abort reset pulse to the core

Ports:
- `clk`  in  1  single clock, 200 MHz domain of `dot11_tx`
- `rstn`  in  1  synchronous, active-low reset
- `enable`  in  1  allow new grants
- `ifs_cycles`  in  16  idle gap after each frame or abort
- `q_req`  in  NUM_Q  level; queue has a staged frame
- `q_base`  in  NUM_Q*AW  per-queue BRAM base address, queue i at bits [i*AW +: AW]
- `q_done`  out  NUM_Q  1-cycle pulse; frame of that queue completed
- `q_err`  out  NUM_Q  1-cycle pulse; frame of that queue aborted on timeout
- `busy`  out  1  high in every state except IDLE
- `cur_q`  out  $clog2(NUM_Q)  index of the granted queue; valid while `busy`
- `phy_tx_start`  out  1  to core
- `phy_tx_started`  in  1  from core
- `phy_tx_done`  in  1  from core
- `phy_tx_arest`  out  1  active-high reset to core, driven during abort
- `core_bram_addr`  in  AW  address from core
- `bram_addr`  out  AW  address to BRAM = `q_base[cur_q] + core_bram_addr`, modulo 2^AW

## Operation
- FSM states: IDLE, ARB, START, WAIT_DONE, ABORT, GAP.
- IDLE → ARB when `enable && |q_req`.
- ARB, one cycle:
  - Pick the first requesting queue at or after the RR pointer, wrapping.
  - Latch `cur_q` and base. Move the pointer to `cur_q+1` mod `NUM_Q`.
  - If no request remains, return to IDLE.
- START:
  - `phy_tx_start` high. Count cycles.
  - `phy_tx_started` → WAIT_DONE with start deasserted. Counter restarts.
  - Count reaches `START_TO` → ABORT.
- WAIT_DONE:
  - `phy_tx_done` → pulse `q_done[cur_q]`, then GAP.
  - Count reaches `FRAME_TO` → ABORT.
  - `phy_tx_started` and `phy_tx_done` in the same cycle: done wins.
- ABORT: `phy_tx_arest` high for `RST_CYCLES` cycles. `q_err[cur_q]` pulses in the first ABORT cycle. Then GAP.
- GAP: wait `ifs_cycles` cycles, then IDLE. `ifs_cycles`=0 goes to IDLE on the next cycle.
- `enable` low mid-frame: the current frame finishes normally; no new ARB.
- `q_req` dropping after grant is ignored. The frame runs to done or abort.
- Address add is 10-bit wrapping, with no carry out. Base `0x3F0` + core `0x020` = `0x010`.
- `bram_addr` is combinational from registered `cur_q`/base and the core address. Do not register it: the core expects BRAM data one cycle after the address.

## Timing
- Reset (`rstn` low at a `clk` edge):
  - State to IDLE. RR pointer to 0. Counters to 0.
  - `phy_tx_start`, `phy_tx_arest`, `q_done`, `q_err`, `busy`, `cur_q` all 0.
  - `bram_addr` = `q_base[0]` + `core_bram_addr`.
- Reset mid-frame drops `phy_tx_start` immediately and does not pulse `q_done` or `q_err`. Resetting the core is the system's job.
- Latency from a request in IDLE:
  - Cycle 0: `q_req` sampled.
  - Cycle 1: ARB.
  - Cycle 2: `phy_tx_start` first high.
- After `phy_tx_done` is sampled, `q_done` is high on the following cycle, together with the first GAP cycle.
- Earliest re-grant is `ifs_cycles`+2 cycles after the `q_done` pulse.
- All outputs except `bram_addr` are registered.

## Structure
- Shared package `dot11_tx_pkg`: FSM state enum and `AW`.
- Sub-module `rr_arbiter` (`NUM_Q`, request vector, pointer in, grant index and valid out), purely combinational. It is reused by other queue muxes.
- Counters and FSM live in `dot11_tx_sched`. Expect about 200 lines of RTL.

## Test plan
- Single frame:
  - Setup: queue 1 requests, base `0x100`, core stub pulses started at +3 and done at +50, `ifs_cycles`=10.
  - Start is high cycles 2–5. `bram_addr` = `0x100`+core.
  - One `q_done[1]` pulse. `busy` falls 11 cycles after done.
- Round-robin:
  - Setup: all 4 queues request continuously.
  - Grant order is 0,1,2,3,0. Skipping queue 2's request gives 0,1,3,0.
- Start timeout:
  - Setup: core never asserts started.
  - Start drops after 64 cycles. `phy_tx_arest` is high for 4 cycles. `q_err[cur_q]` pulses once. The next queue is granted after the gap.
- Frame timeout with `FRAME_TO`=100:
  - Setup: started arrives, done never does.
  - Abort happens 100 cycles after started.
- Wrap and enable:
  - Base `0x3F0`, core address `0x020` → `bram_addr` `0x010`.
  - Drop `enable` mid-frame: the frame completes and no further grant occurs.
- Reset mid-WAIT_DONE:
  - All outputs are 0 on the next cycle with no `q_done`. After release the RR pointer is 0 and queue 0 is granted first.
